// File: rtl/wb_commit_unit_pkg.sv
// Shared types and constants for the writeback commit / exception sequencer.
// Imported by wb_commit_unit.
package wb_commit_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT,
        S_HANDLER,
        S_HALT
    } state_e;

    localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_2000;
    localparam logic [4:0]  REG_ZERO           = 5'd0;

endpackage

// File: rtl/wb_commit_unit.sv
// Writeback commit and exception sequencer: drives the register file write port,
// the rm[0]/rm[1] exception registers, pipe flush and fetch redirect.
module wb_commit_unit
    import wb_commit_unit_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC   = HANDLER_PC_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic        wb_regWrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_value,
    input  logic        wb_exception,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_faulty_address,
    input  logic        wb_iret,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rm_we,
    output logic [31:0] rm_pc,
    output logic [31:0] rm_addr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        in_handler,
    output logic        double_fault
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] target_q, target_d;
    logic [31:0] saved_pc_q, saved_pc_d;
    logic        to_handler_q, to_handler_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic        rm_we_q, rm_we_d;
    logic [31:0] rm_pc_q, rm_pc_d;
    logic [31:0] rm_addr_q, rm_addr_d;
    logic        flush_q, flush_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        in_handler_q, in_handler_d;
    logic        double_fault_q, double_fault_d;

    logic commit;
    logic fault;

    assign commit = wb_valid & wb_regWrite & ~wb_exception & (wb_rd != REG_ZERO);
    assign fault  = wb_valid & wb_exception;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        target_d         = target_q;
        saved_pc_d       = saved_pc_q;
        to_handler_d     = to_handler_q;
        rf_we_d          = 1'b0;
        rf_waddr_d       = rf_waddr_q;
        rf_wdata_d       = rf_wdata_q;
        rm_we_d          = 1'b0;
        rm_pc_d          = rm_pc_q;
        rm_addr_d        = rm_addr_q;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        double_fault_d   = 1'b0;

        unique case (state_q)
            S_IDLE, S_HANDLER: begin
                if (fault) begin
                    // A fault while already in the handler cannot be recovered from.
                    if (state_q == S_HANDLER) begin
                        state_d        = S_HALT;
                        flush_d        = 1'b1;
                        double_fault_d = 1'b1;
                    end else begin
                        rm_we_d      = 1'b1;
                        rm_pc_d      = wb_pc;
                        rm_addr_d    = wb_faulty_address;
                        saved_pc_d   = wb_pc;
                        target_d     = HANDLER_PC;
                        to_handler_d = 1'b1;
                        cnt_d        = FLUSH_LOAD;
                        flush_d      = 1'b1;
                        state_d      = S_FLUSH;
                    end
                end else begin
                    if (commit) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = wb_rd;
                        rf_wdata_d = wb_value;
                    end
                    // iret outside the handler is a nop apart from its write.
                    if ((state_q == S_HANDLER) && wb_valid && wb_iret) begin
                        target_d     = saved_pc_q;
                        to_handler_d = 1'b0;
                        cnt_d        = FLUSH_LOAD;
                        flush_d      = 1'b1;
                        state_d      = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d          = S_REDIRECT;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = target_q;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            S_REDIRECT: begin
                state_d = to_handler_q ? S_HANDLER : S_IDLE;
            end
            S_HALT: begin
                flush_d        = 1'b1;
                double_fault_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_handler_d = (state_d == S_HANDLER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            cnt_q            <= 4'd0;
            target_q         <= 32'd0;
            saved_pc_q       <= 32'd0;
            to_handler_q     <= 1'b0;
            rf_we_q          <= 1'b0;
            rf_waddr_q       <= 5'd0;
            rf_wdata_q       <= 32'd0;
            rm_we_q          <= 1'b0;
            rm_pc_q          <= 32'd0;
            rm_addr_q        <= 32'd0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            in_handler_q     <= 1'b0;
            double_fault_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            target_q         <= target_d;
            saved_pc_q       <= saved_pc_d;
            to_handler_q     <= to_handler_d;
            rf_we_q          <= rf_we_d;
            rf_waddr_q       <= rf_waddr_d;
            rf_wdata_q       <= rf_wdata_d;
            rm_we_q          <= rm_we_d;
            rm_pc_q          <= rm_pc_d;
            rm_addr_q        <= rm_addr_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            in_handler_q     <= in_handler_d;
            double_fault_q   <= double_fault_d;
        end
    end

    assign rf_we          = rf_we_q;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;
    assign rm_we          = rm_we_q;
    assign rm_pc          = rm_pc_q;
    assign rm_addr        = rm_addr_q;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign in_handler     = in_handler_q;
    assign double_fault   = double_fault_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboard bench for wb_commit_unit: directed test-plan sequences followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_wb_commit_unit;

    localparam logic [31:0] HPC = 32'h0000_2000;
    localparam int          NF  = 3;

    localparam int M_NORM = 0;
    localparam int M_HAND = 1;
    localparam int M_BUSY = 2;
    localparam int M_HALT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_regWrite = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_value = 32'd0;
    logic        wb_exception = 1'b0;
    logic [31:0] wb_pc = 32'd0;
    logic [31:0] wb_faulty_address = 32'd0;
    logic        wb_iret = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rm_we;
    logic [31:0] rm_pc;
    logic [31:0] rm_addr;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        in_handler;
    logic        double_fault;

    always #5 clk = ~clk;

    wb_commit_unit #(.HANDLER_PC(HPC), .FLUSH_CYCLES(NF)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_rd(wb_rd),
        .wb_value(wb_value), .wb_exception(wb_exception), .wb_pc(wb_pc),
        .wb_faulty_address(wb_faulty_address), .wb_iret(wb_iret),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rm_we(rm_we), .rm_pc(rm_pc), .rm_addr(rm_addr),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .in_handler(in_handler), .double_fault(double_fault)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [36:0] rf_exp_q[$];
    logic [63:0] rm_exp_q[$];
    logic [31:0] rd_exp_q[$];
    logic [5:0]  st_exp_q[$];

    // Reference model: what the unit does per instruction, not how.
    int          mode = M_NORM;
    int          busy_left = 0;
    logic [31:0] m_saved = 32'd0;
    logic [31:0] m_target = 32'd0;
    bit          m_exc_route = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_event(input logic [31:0] tgt, input bit exc_route);
        m_target    = tgt;
        m_exc_route = exc_route;
        mode        = M_BUSY;
        busy_left   = NF + 1;
    endtask

    task automatic model_step();
        bit rfw = 1'b0;
        bit rmw = 1'b0;
        bit rv  = 1'b0;
        bit fl  = 1'b0;
        bit df  = 1'b0;
        if (mode == M_HALT) begin
            fl = 1'b1;
            df = 1'b1;
        end else if (mode == M_BUSY) begin
            busy_left--;
            if (busy_left > 1) begin
                fl = 1'b1;
            end else if (busy_left == 1) begin
                rv = 1'b1;
                rd_exp_q.push_back(m_target);
            end else begin
                mode = m_exc_route ? M_HAND : M_NORM;
            end
        end else if (wb_valid && wb_exception) begin
            fl = 1'b1;
            if (mode == M_HAND) begin
                mode = M_HALT;
                df   = 1'b1;
            end else begin
                rmw = 1'b1;
                rm_exp_q.push_back({wb_pc, wb_faulty_address});
                m_saved = wb_pc;
                start_event(HPC, 1'b1);
            end
        end else begin
            if (wb_valid && wb_regWrite && wb_rd != 5'd0) begin
                rfw = 1'b1;
                rf_exp_q.push_back({wb_rd, wb_value});
            end
            if (mode == M_HAND && wb_valid && wb_iret) begin
                fl = 1'b1;
                start_event(m_saved, 1'b0);
            end
        end
        st_exp_q.push_back({rfw, rmw, rv, fl, (mode == M_HAND), df});
    endtask

    task automatic step(input logic v, input logic rw, input logic [4:0] rd,
                        input logic [31:0] val, input logic exc, input logic [31:0] pc,
                        input logic [31:0] fa, input logic iret);
        #1;
        wb_valid = v; wb_regWrite = rw; wb_rd = rd; wb_value = val;
        wb_exception = exc; wb_pc = pc; wb_faulty_address = fa; wb_iret = iret;
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic rand_step();
        logic [4:0] rd;
        rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), rd, $urandom,
             ($urandom_range(0, 15) == 0), {$urandom_range(0, 32'hFFFF), 2'b00}, $urandom,
             ($urandom_range(0, 5) == 0));
    endtask

    // Asserts reset mid-cycle and checks that outputs clear without waiting for an edge.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
        wb_valid = 1'b0; wb_exception = 1'b0; wb_iret = 1'b0; wb_regWrite = 1'b0;
        #1;
        chk("reset ctrl outs", {58'd0, rf_we, rm_we, flush, redirect_valid, in_handler, double_fault}, 64'd0);
        chk("reset rf data", {27'd0, rf_waddr, rf_wdata}, 64'd0);
        chk("reset rm data", {rm_pc, rm_addr}, 64'd0);
        chk("reset redirect_pc", {32'd0, redirect_pc}, 64'd0);
        mode = M_NORM; busy_left = 0; m_saved = 32'd0; m_target = 32'd0; m_exc_route = 1'b0;
        rf_exp_q.delete(); rm_exp_q.delete(); rd_exp_q.delete(); st_exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: compares every cycle's control outputs and each strobe's payload.
    always @(negedge clk) begin
        if (st_exp_q.size() > 0) begin
            chk("status rf_we,rm_we,redir,flush,in_handler,double_fault",
                {58'd0, rf_we, rm_we, redirect_valid, flush, in_handler, double_fault},
                {58'd0, st_exp_q.pop_front()});
        end
        if (rf_we) begin
            if (rf_exp_q.size() == 0) chk("unexpected rf write", {27'd0, rf_waddr, rf_wdata}, 64'd0 - 1);
            else chk("rf write addr,data", {27'd0, rf_waddr, rf_wdata}, {27'd0, rf_exp_q.pop_front()});
        end
        if (rm_we) begin
            if (rm_exp_q.size() == 0) chk("unexpected rm write", {rm_pc, rm_addr}, 64'd0 - 1);
            else chk("rm write pc,addr", {rm_pc, rm_addr}, rm_exp_q.pop_front());
        end
        if (redirect_valid) begin
            if (rd_exp_q.size() == 0) chk("unexpected redirect", {32'd0, redirect_pc}, 64'd0 - 1);
            else chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, rd_exp_q.pop_front()});
        end
    end

    initial begin
        int halt_cycles;
        do_reset();

        // Commit, then a dropped r0 write.
        step(1, 1, 5'd5, 32'hDEAD_BEEF, 0, 32'h10, 32'h0, 0);
        step(1, 1, 5'd0, 32'h1234_5678, 0, 32'h14, 32'h0, 0);
        idle(2);

        // Exception entry with writes offered during flush and redirect.
        step(1, 1, 5'd9, 32'hAAAA_0001, 1, 32'h0000_0040, 32'h0000_1FFC, 0);
        for (int i = 0; i < NF + 1; i++) step(1, 1, 5'(10 + i), 32'hBBBB_0000 + i, 0, 32'h44, 32'h0, 0);
        idle(1);

        // Handler write, then iret back to the saved pc.
        step(1, 1, 5'd7, 32'hCAFE_0007, 0, 32'h2000, 32'h0, 0);
        step(1, 1, 5'd8, 32'hCAFE_0008, 0, 32'h2004, 32'h0, 1);
        idle(NF + 3);

        // Re-enter handler, then exception+iret together -> double fault.
        step(1, 0, 5'd0, 32'h0, 1, 32'h0000_0080, 32'h0000_3000, 0);
        idle(NF + 2);
        step(1, 1, 5'd4, 32'h4444_4444, 1, 32'h2010, 32'h5000, 1);
        for (int i = 0; i < 10; i++) rand_step();
        do_reset();

        // Reset landing in the second flush cycle, then a commit.
        step(1, 0, 5'd0, 32'h0, 1, 32'h0000_0100, 32'h0000_0200, 0);
        idle(1);
        do_reset();
        step(1, 1, 5'd12, 32'h0C0C_0C0C, 0, 32'h20, 32'h0, 0);
        idle(NF + 3);

        // iret outside the handler only writes.
        step(1, 1, 5'd3, 32'h3333_3333, 0, 32'h24, 32'h0, 1);
        idle(NF + 3);

        halt_cycles = 0;
        for (int i = 0; i < 600; i++) begin
            rand_step();
            halt_cycles = (mode == M_HALT) ? halt_cycles + 1 : 0;
            if (halt_cycles > 4 || $urandom_range(0, 99) == 0) begin
                do_reset();
                halt_cycles = 0;
            end
        end
        idle(NF + 3);

        @(negedge clk);
        #1;
        chk("pending expectations", {32'd0, 8'(rf_exp_q.size()), 8'(rm_exp_q.size()),
            8'(rd_exp_q.size()), 8'(st_exp_q.size())}, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
Writeback-stage commit and exception sequencer, the write side of the decode-stage register file. It drives the file's register write port and the exception registers rm[0]/rm[1]. On a faulting or iret instruction it squashes in-flight work, flushes the pipe and redirects fetch. Sits between the mem_wb pipeline register and the decode-stage register file and fetch.

Parameters:
HANDLER_PC, 32'h0000_2000, fetch target on exception entry
FLUSH_CYCLES, 3, cycles flush is held high (pipe depth ahead of WB), legal 1..15

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-high; all state and outputs to reset values immediately
wb_valid  in  1  mem_wb holds a real instruction this cycle
wb_regWrite  in  1  instruction writes rd
wb_rd  in  5  destination register
wb_value  in  32  value to write back
wb_exception  in  1  instruction faulted
wb_pc  in  32  pc of instruction
wb_faulty_address  in  32  faulting data address
wb_iret  in  1  instruction is return-from-exception
rf_we  out  1  register file write enable
rf_waddr  out  5  register file write address
rf_wdata  out  32  register file write data
rm_we  out  1  load rm[0]/rm[1]
rm_pc  out  32  value for rm[0]
rm_addr  out  32  value for rm[1]
flush  out  1  squash IF/ID/EX/MEM contents
redirect_valid  out  1  one-cycle fetch redirect strobe
redirect_pc  out  32  redirect target
in_handler  out  1  core is executing exception handler
double_fault  out  1  sticky, core halted

Behaviour:
- States: IDLE, FLUSH, REDIRECT, HANDLER, HALT. Reset -> IDLE; all outputs 0; saved-pc and redirect target 0; flush counter 0.
- All outputs registered: one-cycle latency from sampled wb_* to output. Strobes (rf_we, rm_we, redirect_valid) are high exactly one cycle.
- Commit (IDLE or HANDLER): wb_valid & wb_regWrite & !wb_exception & wb_rd!=0 -> next cycle rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_value. Writes to r0 are dropped. wb_valid=0 -> no write.
- Exception in IDLE (wb_valid & wb_exception): the faulting write is suppressed. Next cycle: rm_we=1, rm_pc=wb_pc, rm_addr=wb_faulty_address. wb_pc is also saved internally as the return pc. Target=HANDLER_PC. Go to FLUSH.
- Exception and iret on the same instruction: the exception wins.
- iret in HANDLER (wb_valid & wb_iret & !wb_exception): target=saved pc; go to FLUSH. The iret itself may also commit a write.
- iret in IDLE: treated as a nop; its write is still committed.
- FLUSH: flush=1 for exactly FLUSH_CYCLES cycles, counted by a down-counter. Every wb_valid sampled in this state is ignored: no rf_we, no rm_we, no exception action. Then go to REDIRECT.
- REDIRECT: flush=0, redirect_valid=1, redirect_pc=target for one cycle. Next state is HANDLER if the target is HANDLER_PC from an exception, or IDLE if it came from an iret. Inputs are ignored in this cycle.
- HANDLER: in_handler=1; commits proceed normally.
- Exception in HANDLER: double fault. Write suppressed, rm not overwritten, flush=1 held, go to HALT.
- HALT: double_fault=1 and flush=1 held, all inputs ignored, exits only on reset.
- redirect_pc holds its last value when redirect_valid=0.
- Reset mid-FLUSH or mid-HANDLER: immediate return to IDLE. The saved pc is cleared, and no redirect is issued.

Decomposition:
- Shared package: state encoding enum (IDLE, FLUSH, REDIRECT, HANDLER, HALT), HANDLER_PC default, REG_ZERO=5'd0.
- No sub-module required. The flush down-counter and state register stay inline.

Test Plan:
- Commit: wb_valid=1, regWrite=1, rd=5, value=32'hDEADBEEF -> next cycle rf_we=1, waddr=5, wdata=DEADBEEF for one cycle. Same with rd=0 -> rf_we stays 0.
- Exception: wb_exception=1, pc=32'h0000_0040, faulty=32'h0000_1FFC -> rm_we=1 with those values, no rf_we. Then flush high for 3 cycles with wb_valid/regWrite pulses ignored. Then redirect_valid=1, redirect_pc=32'h0000_2000. Then in_handler=1.
- Iret round trip: from the previous test, a handler write to rd=7 commits. Then wb_iret=1 -> 3 flush cycles, then redirect_pc=32'h0000_0040, state IDLE, in_handler=0.
- Exception and iret together in HANDLER -> double_fault=1 and flush=1 sticky, rm_we=0. Inputs are ignored for 10 cycles, and reset clears all outputs.
- Asynchronous reset asserted in the 2nd FLUSH cycle -> outputs 0 before the next edge, no redirect afterwards. A subsequent commit works.
- iret in IDLE with regWrite, rd=3 -> a normal write only, no flush or redirect.
